// File: rtl/controller_instruction_rom_arbiter_pkg.sv
// controller_rom_arb_pkg: shared widths, port IDs and limits for the instruction memory arbiter
package controller_rom_arb_pkg;
  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W_DEF = DATA_W_DEF / 8;
  localparam int PRIO_RR = 0;
  localparam int PRIO_FIXED = 1;
  localparam logic [7:0] DENIED_MAX = 8'd255;
  typedef enum logic {PORT_FETCH = 1'b0, PORT_DEBUG = 1'b1} port_e;
endpackage

// File: rtl/controller_instruction_rom_arbiter_if.sv
// controller_instruction_rom_arbiter_if: fetch port, debug port and memory-side bus of the arbiter
interface controller_instruction_rom_arbiter_if
  import controller_rom_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BE_W = BE_W_DEF
);
  logic [ADDR_W-1:0] s0_address;
  logic s0_read, s0_waitrequest, s0_readdatavalid;
  logic [DATA_W-1:0] s0_readdata;
  logic [ADDR_W-1:0] s1_address;
  logic s1_read, s1_write, s1_debugaccess, s1_waitrequest, s1_readdatavalid;
  logic [DATA_W-1:0] s1_writedata, s1_readdata;
  logic [BE_W-1:0] s1_byteenable;
  logic [ADDR_W-1:0] mem_address;
  logic mem_chipselect, mem_write, mem_debugaccess, mem_clken;
  logic [DATA_W-1:0] mem_writedata, mem_readdata;
  logic [BE_W-1:0] mem_byteenable;
  modport slave (
    input s0_address, s0_read, s1_address, s1_read, s1_write, s1_writedata, s1_byteenable,
    input s1_debugaccess, mem_readdata,
    output s0_waitrequest, s0_readdata, s0_readdatavalid, s1_waitrequest, s1_readdata,
    output s1_readdatavalid, mem_address, mem_chipselect, mem_write, mem_writedata,
    output mem_byteenable, mem_debugaccess, mem_clken
  );
  modport master (
    output s0_address, s0_read, s1_address, s1_read, s1_write, s1_writedata, s1_byteenable,
    output s1_debugaccess, mem_readdata,
    input s0_waitrequest, s0_readdata, s0_readdatavalid, s1_waitrequest, s1_readdata,
    input s1_readdatavalid, mem_address, mem_chipselect, mem_write, mem_writedata,
    input mem_byteenable, mem_debugaccess, mem_clken
  );
endinterface

// File: rtl/controller_instruction_rom_arbiter_rr_arbiter_2.sv
// rr_arbiter_2: two-request same-cycle grant with a last_grant register for round-robin fairness
module rr_arbiter_2
  import controller_rom_arb_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  logic last_q, last_d, pick1;
  // last_q=1 means the debug port won most recently, so fetch wins the next conflict
  always_comb begin
    pick1 = req_i[1] & (~req_i[0] | (PRIO_MODE == PRIO_RR && !last_q));
    gnt_o = en_i ? {pick1, req_i[0] & ~pick1} : 2'b00;
    last_d = |gnt_o ? gnt_o[1] : last_q;
  end
  always_ff @(posedge clk)
    if (!reset_n) last_q <= 1'b1;
    else last_q <= last_d;
endmodule

// File: rtl/controller_instruction_rom_arbiter.sv
// controller_instruction_rom_arbiter: shares one single-port instruction memory between fetch and debug masters
module controller_instruction_rom_arbiter
  import controller_rom_arb_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic clk,
  input  logic reset_n,
  input  logic reset_req,
  controller_instruction_rom_arbiter_if.slave bus,
  output logic [7:0] denied_count
);
  logic [1:0] req, gnt;
  logic wr_go, wr_ok, rd_go, rd_pend_q, rd_pend_d;
  port_e rd_owner_q, rd_owner_d;
  logic [7:0] cnt_q, cnt_d;
  assign req = {bus.s1_read | bus.s1_write, bus.s0_read};
  rr_arbiter_2 #(.PRIO_MODE(PRIO_MODE)) u_arb (
    .clk(clk),
    .reset_n(reset_n),
    .en_i(reset_n & ~reset_req),
    .req_i(req),
    .gnt_o(gnt)
  );
  // a dropped write is accepted on the bus but never reaches the memory
  always_comb begin
    wr_go = gnt[1] & bus.s1_write;
    wr_ok = wr_go & bus.s1_debugaccess;
    rd_go = gnt[0] | (gnt[1] & ~bus.s1_write);
    bus.s0_waitrequest = req[0] & ~gnt[0];
    bus.s1_waitrequest = req[1] & ~gnt[1];
    bus.mem_address = gnt[1] ? bus.s1_address : bus.s0_address;
    bus.mem_chipselect = rd_go | wr_ok;
    bus.mem_write = wr_ok;
    bus.mem_debugaccess = wr_ok;
    bus.mem_writedata = bus.s1_writedata;
    bus.mem_byteenable = bus.s1_byteenable;
    bus.mem_clken = ~reset_req;
    bus.s0_readdata = bus.mem_readdata;
    bus.s1_readdata = bus.mem_readdata;
    bus.s0_readdatavalid = reset_n & rd_pend_q & (rd_owner_q == PORT_FETCH);
    bus.s1_readdatavalid = reset_n & rd_pend_q & (rd_owner_q == PORT_DEBUG);
    rd_pend_d = rd_go;
    rd_owner_d = gnt[1] ? PORT_DEBUG : PORT_FETCH;
    cnt_d = (wr_go && !bus.s1_debugaccess && cnt_q != DENIED_MAX) ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      rd_pend_q <= 1'b0;
      rd_owner_q <= PORT_FETCH;
      cnt_q <= 8'd0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      cnt_q <= cnt_d;
    end
  assign denied_count = cnt_q;
endmodule

// File: tb/tb_controller_instruction_rom_arbiter.sv
// tb_controller_instruction_rom_arbiter: directed checks of grant order, read return, write gating and resets
module tb_controller_instruction_rom_arbiter;
  import controller_rom_arb_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0, reset_req = 1'b0;
  logic [7:0] den_rr, den_fx;
  logic [31:0] mem [8192];
  logic [31:0] q_rr, q_fx;
  int total = 0, bad = 0;
  int n0, n1;
  logic wr_seen;
  always #5 clk = ~clk;
  controller_instruction_rom_arbiter_if b_rr ();
  controller_instruction_rom_arbiter_if b_fx ();
  controller_instruction_rom_arbiter #(.PRIO_MODE(PRIO_RR)) u_rr (
    .clk(clk), .reset_n(reset_n), .reset_req(reset_req), .bus(b_rr), .denied_count(den_rr)
  );
  controller_instruction_rom_arbiter #(.PRIO_MODE(PRIO_FIXED)) u_fx (
    .clk(clk), .reset_n(reset_n), .reset_req(reset_req), .bus(b_fx), .denied_count(den_fx)
  );
  always @(posedge clk)
    if (b_rr.mem_clken && b_rr.mem_chipselect) begin
      if (b_rr.mem_write)
        for (int b = 0; b < 4; b++)
          if (b_rr.mem_byteenable[b]) mem[b_rr.mem_address][8*b +: 8] <= b_rr.mem_writedata[8*b +: 8];
      q_rr <= mem[b_rr.mem_address];
    end
  always @(posedge clk) q_fx <= {19'h0, b_fx.mem_address};
  assign b_rr.mem_readdata = q_rr;
  assign b_fx.mem_readdata = q_fx;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'hA500_0000 | i;
    {b_rr.s0_address, b_rr.s0_read, b_rr.s1_address, b_rr.s1_read, b_rr.s1_write} = '0;
    {b_rr.s1_writedata, b_rr.s1_byteenable, b_rr.s1_debugaccess} = '0;
    {b_fx.s0_address, b_fx.s0_read, b_fx.s1_address, b_fx.s1_read, b_fx.s1_write} = '0;
    {b_fx.s1_writedata, b_fx.s1_byteenable, b_fx.s1_debugaccess} = '0;
    b_rr.s0_address = 13'h0010; b_rr.s0_read = 1'b1;
    b_rr.s1_address = 13'h0020; b_rr.s1_read = 1'b1;
    repeat (3) tick;
    chk("rst_rdv0", b_rr.s0_readdatavalid, 0);
    chk("rst_rdv1", b_rr.s1_readdatavalid, 0);
    chk("rst_cs", b_rr.mem_chipselect, 0);
    chk("rst_den", den_rr, 0);
    chk("rst_wait0", b_rr.s0_waitrequest, 1);
    reset_n = 1'b1;
    #1;
    chk("first_wait0", b_rr.s0_waitrequest, 0);
    chk("first_wait1", b_rr.s1_waitrequest, 1);
    chk("first_addr", b_rr.mem_address, 32'h10);
    chk("first_cs", b_rr.mem_chipselect, 1);
    tick;
    b_rr.s0_read = 1'b0;
    #1;
    chk("first_rdv0", b_rr.s0_readdatavalid, 1);
    chk("first_data0", b_rr.s0_readdata, 32'hA500_0010);
    chk("second_wait1", b_rr.s1_waitrequest, 0);
    chk("second_addr", b_rr.mem_address, 32'h20);
    tick;
    b_rr.s1_read = 1'b0;
    #1;
    chk("second_rdv1", b_rr.s1_readdatavalid, 1);
    chk("second_data1", b_rr.s1_readdata, 32'hA500_0020);
    chk("second_rdv0", b_rr.s0_readdatavalid, 0);
    // round-robin: both ports streaming reads
    b_rr.s0_address = 13'h0100; b_rr.s0_read = 1'b1;
    b_rr.s1_address = 13'h0101; b_rr.s1_read = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (i < 4) chk("rr_alt_wait0", b_rr.s0_waitrequest, i % 2);
      tick;
      n0 += int'(b_rr.s0_readdatavalid);
      n1 += int'(b_rr.s1_readdatavalid);
    end
    b_rr.s0_read = 1'b0; b_rr.s1_read = 1'b0;
    chk("rr_n0", n0, 50);
    chk("rr_n1", n1, 50);
    tick;
    // fixed priority: debug starves while fetch requests
    b_fx.s0_address = 13'h0003; b_fx.s0_read = 1'b1;
    b_fx.s1_address = 13'h0004; b_fx.s1_read = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      tick;
      n0 += int'(b_fx.s0_readdatavalid);
      n1 += int'(b_fx.s1_readdatavalid);
    end
    chk("fx_n0", n0, 20);
    chk("fx_n1", n1, 0);
    chk("fx_wait1", b_fx.s1_waitrequest, 1);
    chk("fx_data0", b_fx.s0_readdata, 32'h3);
    b_fx.s0_read = 1'b0;
    #1;
    chk("fx_wait1_free", b_fx.s1_waitrequest, 0);
    tick;
    b_fx.s1_read = 1'b0;
    // byte-masked debug write then read-back
    b_rr.s1_address = 13'h1FFF; b_rr.s1_writedata = 32'hDEAD_BEEF;
    b_rr.s1_byteenable = 4'h3; b_rr.s1_debugaccess = 1'b1; b_rr.s1_write = 1'b1;
    #1;
    chk("wr_mem_write", b_rr.mem_write, 1);
    chk("wr_mem_dbg", b_rr.mem_debugaccess, 1);
    chk("wr_wait1", b_rr.s1_waitrequest, 0);
    tick;
    b_rr.s1_write = 1'b0; b_rr.s1_read = 1'b1;
    #1;
    chk("rb_mem_write", b_rr.mem_write, 0);
    tick;
    b_rr.s1_read = 1'b0;
    #1;
    chk("rb_rdv1", b_rr.s1_readdatavalid, 1);
    chk("rb_data", b_rr.s1_readdata, 32'hA500_BEEF);
    // writes without debugaccess are dropped and counted
    b_rr.s1_address = 13'h0005; b_rr.s1_writedata = 32'h0;
    b_rr.s1_byteenable = 4'hF; b_rr.s1_debugaccess = 1'b0; b_rr.s1_write = 1'b1;
    wr_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      #1;
      chk("deny_wait1", b_rr.s1_waitrequest, 0);
      wr_seen |= b_rr.mem_write;
      tick;
      if (i == 0) chk("deny_first", den_rr, 1);
    end
    b_rr.s1_write = 1'b0;
    chk("deny_sat", den_rr, 255);
    chk("deny_nowrite", wr_seen, 0);
    chk("deny_mem", mem[5], 32'hA500_0005);
    // reset_req holds off grants
    b_rr.s0_address = 13'h0030; b_rr.s0_read = 1'b1;
    reset_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rreq_wait0", b_rr.s0_waitrequest, 1);
      chk("rreq_clken", b_rr.mem_clken, 0);
      chk("rreq_cs", b_rr.mem_chipselect, 0);
      tick;
    end
    reset_req = 1'b0;
    #1;
    chk("rreq_go_wait0", b_rr.s0_waitrequest, 0);
    chk("rreq_go_clken", b_rr.mem_clken, 1);
    tick;
    b_rr.s0_read = 1'b0;
    #1;
    chk("rreq_rdv0", b_rr.s0_readdatavalid, 1);
    chk("rreq_data0", b_rr.s0_readdata, 32'hA500_0030);
    tick;
    // reset_n pulse discards the in-flight read
    b_rr.s0_address = 13'h0040; b_rr.s0_read = 1'b1;
    tick;
    b_rr.s0_read = 1'b0; reset_n = 1'b0;
    #1;
    chk("rpulse_rdv0", b_rr.s0_readdatavalid, 0);
    tick;
    chk("rpulse_rdv0_b", b_rr.s0_readdatavalid, 0);
    chk("rpulse_rdv1", b_rr.s1_readdatavalid, 0);
    chk("rpulse_den", den_rr, 0);
    chk("rpulse_cs", b_rr.mem_chipselect, 0);
    b_rr.s0_address = 13'h0060; b_rr.s0_read = 1'b1;
    b_rr.s1_address = 13'h0050; b_rr.s1_read = 1'b1;
    reset_n = 1'b1;
    #1;
    chk("rpulse_last_wait0", b_rr.s0_waitrequest, 0);
    chk("rpulse_last_wait1", b_rr.s1_waitrequest, 1);
    tick;
    b_rr.s0_read = 1'b0; b_rr.s1_read = 1'b0;
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
